onehot_mux_reg: RTL and testbench
=================================

# onehot_mux_reg

Parametrised registered one-hot multiplexer, the successor to the fixed 8-input, 16-bit combinational select mux in the datapath. It selects one of `NUM_IN` `WIDTH`-bit channels using a one-hot select and registers the result behind a valid/ready handshake. It detects and counts malformed selects, and reports the selected channel index. It sits between register-file/immediate sources and the ALU operand latches, where operand selection must be pipelined and stallable.

## Interface
Parameters:
- `WIDTH`, 16, data width per channel
- `NUM_IN`, 8, number of input channels (≥2)
- `MODE`, 0, 0 = STRICT (select must be exactly one-hot), 1 = PRIORITY (highest set bit wins)
- `ERR_CNT_W`, 8, width of the saturating error counter

Ports:
- `CLK`  in  1  sole clock, rising edge
- `RST_N`  in  1  reset, synchronous, active-low
- `S`  in  NUM_IN  one-hot select; bit k selects channel k
- `IN`  in  NUM_IN*WIDTH  flattened channels; channel k at `IN[k*WIDTH +: WIDTH]`
- `IN_VALID`  in  1  input beat valid
- `IN_READY`  out  1  block can accept a beat
- `O`  out  WIDTH  registered selected data
- `O_IDX`  out  clog2(NUM_IN)  index of the channel that produced `O`
- `O_VALID`  out  1  `O`/`O_IDX` valid
- `O_READY`  in  1  downstream accepts
- `SEL_ERR`  out  1  one-cycle pulse: an accepted beat had an illegal select
- `ERR_CNT`  out  ERR_CNT_W  saturating count of illegal selects
- `CLR_ERR`  in  1  synchronous clear of `ERR_CNT`

## Operation
- Accept: `IN_READY = !O_VALID || O_READY` (combinational). A beat transfers when `IN_VALID && IN_READY`.
- Legality rules:
  - STRICT: legal only if exactly one bit of `S` is set.
  - PRIORITY: legal if any bit is set, and the highest set index wins.
  - `S == 0` is illegal in both modes.
- Legal accepted beat: `O` and `O_IDX` load from the selected channel. `O_VALID` is 1 next cycle.
- Illegal accepted beat:
  - The beat is consumed and dropped.
  - `O` and `O_IDX` hold their previous values.
  - `O_VALID` is 0 next cycle, unless it was 1 and `O_READY` was 0; that case cannot occur because `IN_READY` was 0.
  - `SEL_ERR` is 1 next cycle.
  - `ERR_CNT` increments, saturating at all-ones.
- No accept while `O_VALID && O_READY`: `O_VALID` is 0 next cycle and `O` holds.
- `O_VALID && !O_READY`: `O`, `O_IDX` and `O_VALID` are stable.
- `CLR_ERR` has priority over an increment in the same cycle: `ERR_CNT` is 0 next cycle. `SEL_ERR` still pulses.
- Reset (`RST_N = 0` at an edge): `O = 0`, `O_IDX = 0`, `O_VALID = 0`, `SEL_ERR = 0`, `ERR_CNT = 0`.
  - Any in-flight beat is discarded.
  - `IN_READY` reads 1 from the first cycle after reset.

## Timing
- Latency is 1 cycle from accept to `O_VALID`. Throughput is 1 beat/cycle when `O_READY` is held high.
- No combinational path from `IN`/`S` to `O`. The only combinational path is `O_READY` to `IN_READY`.
- `SEL_ERR` is registered and aligned to the cycle in which the result would have appeared.
- `ERR_CNT` updates on the same edge that sets `SEL_ERR`.

## Structure
- Package `onehot_mux_pkg`:
  - `MODE_STRICT` and `MODE_PRIORITY` constants.
  - An `idx_w(n)` function returning the clog2 width, with a minimum of 1.
- Sub-module `onehot_encoder` is combinational:
  - Inputs: `S`, `MODE`.
  - Outputs: index and `legal`.
  - Performs the popcount/priority decode.
- Top level holds the data mux (AND-OR using the decoded index), output register, handshake and error counter.

## Test plan
Default parameters. Channels 0–7 = 5, 10, 15, 20, 25, 30, 35, 40.
- Basic select: `S = 8'h80`, `IN_VALID = 1`, `O_READY = 1` → next cycle `O = 40`, `O_IDX = 7`, `O_VALID = 1`. Sweeping `S = 1 << k` across 8 consecutive cycles → `O = 5, 10, …, 40`, one per cycle.
- Backpressure:
  - Accept `S = 8'h04` with `O_READY = 0` → `O = 15` held, `IN_READY = 0` for 3 cycles while `S` changes.
  - Raise `O_READY` → next beat accepted that cycle.
- Illegal select in STRICT: `S = 8'h81` → `SEL_ERR` pulses once, `ERR_CNT = 1`, `O_VALID = 0`, `O` keeps its prior value. `S = 0` → `ERR_CNT = 2`.
- PRIORITY mode: `MODE = 1`, `S = 8'h81` → `O = 40`, `O_IDX = 7`, no error. `S = 0` → `SEL_ERR`.
- Counter behaviour:
  - With `ERR_CNT_W = 2`, 5 illegal beats → `ERR_CNT = 3`.
  - `CLR_ERR` asserted together with a 6th illegal beat → `ERR_CNT = 0` and `SEL_ERR = 1`.
- Reset mid-transfer: `O_VALID = 1`, `O_READY = 0`, then `RST_N = 0` for 1 cycle → `O = 0`, `O_VALID = 0`, `ERR_CNT = 0`, `IN_READY = 1` on the following cycle.

Source files
------------

// File: rtl/onehot_mux_pkg.sv
// Shared constants and helpers for the registered one-hot operand multiplexer.
package onehot_mux_pkg;

    // Select-decoding modes: STRICT needs exactly one bit, PRIORITY takes the highest set bit.
    localparam logic MODE_STRICT   = 1'b0;
    localparam logic MODE_PRIORITY = 1'b1;

    // Width of an index into n channels, never narrower than one bit.
    function automatic int idx_w(input int n);
        int w;
        w = $clog2(n);
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/onehot_encoder.sv
// Combinational select decoder: turns a one-hot (or priority) select into a channel index
// and reports whether the select pattern is legal for the chosen mode.
module onehot_encoder
    import onehot_mux_pkg::*;
#(
    parameter int NUM_IN = 8,
    parameter int IDX_W  = idx_w(NUM_IN)
) (
    input  logic [NUM_IN-1:0] s,
    input  logic              mode,
    output logic [IDX_W-1:0]  idx,
    output logic              legal
);

    int ones;

    // Scan upward so the highest set bit ends up as the index; count set bits alongside.
    always_comb begin
        ones  = 0;
        idx   = '0;
        legal = 1'b0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (s[k]) begin
                idx  = IDX_W'(k);
                ones = ones + 1;
            end
        end
        if (mode == MODE_PRIORITY) begin
            legal = (s != '0);
        end else begin
            legal = (ones == 1);
        end
    end

endmodule

// File: rtl/onehot_mux_reg.sv
// Registered one-hot operand multiplexer with valid/ready handshake, illegal-select
// detection and a saturating error counter.
module onehot_mux_reg
    import onehot_mux_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int NUM_IN    = 8,
    parameter int MODE      = 0,
    parameter int ERR_CNT_W = 8
) (
    input  logic                        CLK,
    input  logic                        RST_N,
    input  logic [NUM_IN-1:0]           S,
    input  logic [NUM_IN*WIDTH-1:0]     IN,
    input  logic                        IN_VALID,
    output logic                        IN_READY,
    output logic [WIDTH-1:0]            O,
    output logic [idx_w(NUM_IN)-1:0]    O_IDX,
    output logic                        O_VALID,
    input  logic                        O_READY,
    output logic                        SEL_ERR,
    output logic [ERR_CNT_W-1:0]        ERR_CNT,
    input  logic                        CLR_ERR
);

    localparam int   IDX_W    = idx_w(NUM_IN);
    localparam logic MODE_BIT = (MODE == 1) ? MODE_PRIORITY : MODE_STRICT;

    logic [IDX_W-1:0]     sel_idx;
    logic                 sel_legal;
    logic [WIDTH-1:0]     mux_data;
    logic                 in_ready;
    logic                 accept;

    logic [WIDTH-1:0]     o_d, o_q;
    logic [IDX_W-1:0]     o_idx_d, o_idx_q;
    logic                 o_valid_d, o_valid_q;
    logic                 sel_err_d, sel_err_q;
    logic [ERR_CNT_W-1:0] err_cnt_d, err_cnt_q;

    onehot_encoder #(
        .NUM_IN (NUM_IN),
        .IDX_W  (IDX_W)
    ) u_encoder (
        .s      (S),
        .mode   (MODE_BIT),
        .idx    (sel_idx),
        .legal  (sel_legal)
    );

    // AND-OR data mux steered by the decoded index, so exactly one channel reaches the register.
    always_comb begin
        mux_data = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            mux_data |= IN[k*WIDTH +: WIDTH] & {WIDTH{sel_idx == IDX_W'(k)}};
        end
    end

    // The output slot frees up when it is empty or being drained this cycle.
    always_comb begin
        in_ready = !o_valid_q || O_READY;
        accept   = IN_VALID && in_ready;
    end

    // Next-state: load legal beats, drop illegal ones with an error pulse, hold under backpressure.
    always_comb begin
        o_d       = o_q;
        o_idx_d   = o_idx_q;
        o_valid_d = o_valid_q && !O_READY;
        sel_err_d = 1'b0;
        err_cnt_d = err_cnt_q;
        if (accept) begin
            if (sel_legal) begin
                o_d       = mux_data;
                o_idx_d   = sel_idx;
                o_valid_d = 1'b1;
            end else begin
                o_valid_d = 1'b0;
                sel_err_d = 1'b1;
                if (err_cnt_q != '1) begin
                    err_cnt_d = err_cnt_q + 1'b1;
                end
            end
        end
        if (CLR_ERR) begin
            err_cnt_d = '0;
        end
    end

    // Output and error registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            o_q       <= '0;
            o_idx_q   <= '0;
            o_valid_q <= 1'b0;
            sel_err_q <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            o_q       <= o_d;
            o_idx_q   <= o_idx_d;
            o_valid_q <= o_valid_d;
            sel_err_q <= sel_err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign IN_READY = in_ready;
    assign O        = o_q;
    assign O_IDX    = o_idx_q;
    assign O_VALID  = o_valid_q;
    assign SEL_ERR  = sel_err_q;
    assign ERR_CNT  = err_cnt_q;

endmodule

// File: tb/tb_onehot_mux_reg.sv
// Bench for onehot_mux_reg: three instances (STRICT, PRIORITY, STRICT with a 2-bit counter)
// share stimulus and are each compared to a behavioural model every cycle.
module tb_onehot_mux_reg;

    logic         CLK = 1'b0;
    logic         RST_N;
    logic [7:0]   s;
    logic [127:0] in_bus;
    logic         in_valid, o_ready, clr_err;
    logic [15:0]  chan [8];

    logic         dut_ready [3];
    logic [15:0]  dut_o     [3];
    logic [2:0]   dut_idx   [3];
    logic         dut_valid [3];
    logic         dut_err   [3];
    logic [7:0]   cnt0, cnt1;
    logic [1:0]   cnt2;

    int checks   = 0;
    int failures = 0;

    logic [15:0] m_o     [3];
    int          m_idx   [3];
    bit          m_valid [3];
    bit          m_err   [3];
    int          m_cnt   [3];
    int          mode_of [3] = '{0, 1, 0};
    int          cnt_max [3] = '{255, 255, 3};

    typedef struct {
        logic [7:0] s;
        bit v, r, c;
        bit ready;
        int o, idx;
        bit ov, err;
        int cnt;
    } vec_t;
    vec_t tbl [21];

    always #5 CLK = ~CLK;

    for (genvar g = 0; g < 8; g++) begin : g_bus
        assign in_bus[g*16 +: 16] = chan[g];
    end

    onehot_mux_reg #(.WIDTH(16), .NUM_IN(8), .MODE(0), .ERR_CNT_W(8)) u_strict (
        .CLK(CLK), .RST_N(RST_N), .S(s), .IN(in_bus), .IN_VALID(in_valid),
        .IN_READY(dut_ready[0]), .O(dut_o[0]), .O_IDX(dut_idx[0]), .O_VALID(dut_valid[0]),
        .O_READY(o_ready), .SEL_ERR(dut_err[0]), .ERR_CNT(cnt0), .CLR_ERR(clr_err));

    onehot_mux_reg #(.WIDTH(16), .NUM_IN(8), .MODE(1), .ERR_CNT_W(8)) u_prio (
        .CLK(CLK), .RST_N(RST_N), .S(s), .IN(in_bus), .IN_VALID(in_valid),
        .IN_READY(dut_ready[1]), .O(dut_o[1]), .O_IDX(dut_idx[1]), .O_VALID(dut_valid[1]),
        .O_READY(o_ready), .SEL_ERR(dut_err[1]), .ERR_CNT(cnt1), .CLR_ERR(clr_err));

    onehot_mux_reg #(.WIDTH(16), .NUM_IN(8), .MODE(0), .ERR_CNT_W(2)) u_small (
        .CLK(CLK), .RST_N(RST_N), .S(s), .IN(in_bus), .IN_VALID(in_valid),
        .IN_READY(dut_ready[2]), .O(dut_o[2]), .O_IDX(dut_idx[2]), .O_VALID(dut_valid[2]),
        .O_READY(o_ready), .SEL_ERR(dut_err[2]), .ERR_CNT(cnt2), .CLR_ERR(clr_err));

    function automatic logic [31:0] dut_cnt(input int i);
        case (i)
            0:       return 32'(cnt0);
            1:       return 32'(cnt1);
            default: return 32'(cnt2);
        endcase
    endfunction

    task automatic check(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s inst%0d: got %0h expected %0h at %0t", name, inst, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [7:0] sv, input bit v, input bit r, input bit c);
        s        = sv;
        in_valid = v;
        o_ready  = r;
        clr_err  = c;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_o[i] = '0; m_idx[i] = 0; m_valid[i] = 0; m_err[i] = 0; m_cnt[i] = 0;
        end
    endtask

    task automatic check_outputs();
        for (int i = 0; i < 3; i++) begin
            check("O", i, 32'(dut_o[i]), 32'(m_o[i]));
            check("O_IDX", i, 32'(dut_idx[i]), m_idx[i]);
            check("O_VALID", i, 32'(dut_valid[i]), 32'(m_valid[i]));
            check("SEL_ERR", i, 32'(dut_err[i]), 32'(m_err[i]));
            check("ERR_CNT", i, dut_cnt(i), m_cnt[i]);
        end
    endtask

    // One clock: check the combinational ready, predict from the rules, clock, compare.
    task automatic cycle();
        logic [15:0] n_o [3];
        int n_idx [3], n_cnt [3];
        bit n_valid [3], n_err [3];
        int ones, top;
        bit legal, rdy;
        #1;
        ones = $countones(s);
        top  = (s == 0) ? 0 : $clog2(int'(s) + 1) - 1;
        for (int i = 0; i < 3; i++) begin
            rdy = !m_valid[i] || o_ready;
            check("IN_READY", i, 32'(dut_ready[i]), 32'(rdy));
            legal    = (mode_of[i] == 1) ? (ones > 0) : (ones == 1);
            n_o[i]   = m_o[i];
            n_idx[i] = m_idx[i];
            n_cnt[i] = m_cnt[i];
            n_valid[i] = m_valid[i] && !o_ready;
            n_err[i] = 0;
            if (in_valid && rdy) begin
                if (legal) begin
                    n_o[i] = chan[top]; n_idx[i] = top; n_valid[i] = 1;
                end else begin
                    n_valid[i] = 0; n_err[i] = 1;
                    n_cnt[i] = (m_cnt[i] + 1 > cnt_max[i]) ? cnt_max[i] : m_cnt[i] + 1;
                end
            end
            if (clr_err) n_cnt[i] = 0;
        end
        @(posedge CLK);
        #1;
        if (!RST_N) begin
            model_reset();
        end else begin
            for (int i = 0; i < 3; i++) begin
                m_o[i] = n_o[i]; m_idx[i] = n_idx[i]; m_valid[i] = n_valid[i];
                m_err[i] = n_err[i]; m_cnt[i] = n_cnt[i];
            end
        end
        check_outputs();
    endtask

    initial begin
        for (int k = 0; k < 8; k++) chan[k] = 16'(5 * (k + 1));

        //        s      v  r  c  rdy  O   idx ov err cnt
        tbl[0]  = '{8'h80, 1, 1, 0, 1, 40, 7, 1, 0, 0};
        tbl[1]  = '{8'h01, 1, 1, 0, 1,  5, 0, 1, 0, 0};
        tbl[2]  = '{8'h02, 1, 1, 0, 1, 10, 1, 1, 0, 0};
        tbl[3]  = '{8'h04, 1, 1, 0, 1, 15, 2, 1, 0, 0};
        tbl[4]  = '{8'h08, 1, 1, 0, 1, 20, 3, 1, 0, 0};
        tbl[5]  = '{8'h10, 1, 1, 0, 1, 25, 4, 1, 0, 0};
        tbl[6]  = '{8'h20, 1, 1, 0, 1, 30, 5, 1, 0, 0};
        tbl[7]  = '{8'h40, 1, 1, 0, 1, 35, 6, 1, 0, 0};
        tbl[8]  = '{8'h80, 1, 1, 0, 1, 40, 7, 1, 0, 0};
        tbl[9]  = '{8'h00, 0, 1, 0, 1, 40, 7, 0, 0, 0};
        tbl[10] = '{8'h04, 1, 0, 0, 1, 15, 2, 1, 0, 0};
        tbl[11] = '{8'h08, 1, 0, 0, 0, 15, 2, 1, 0, 0};
        tbl[12] = '{8'h10, 1, 0, 0, 0, 15, 2, 1, 0, 0};
        tbl[13] = '{8'h20, 1, 0, 0, 0, 15, 2, 1, 0, 0};
        tbl[14] = '{8'h20, 1, 1, 0, 1, 30, 5, 1, 0, 0};
        tbl[15] = '{8'h81, 1, 1, 0, 1, 30, 5, 0, 1, 1};
        tbl[16] = '{8'h00, 1, 1, 0, 1, 30, 5, 0, 1, 2};
        tbl[17] = '{8'h02, 1, 1, 0, 1, 10, 1, 1, 0, 2};
        tbl[18] = '{8'h00, 0, 1, 0, 1, 10, 1, 0, 0, 2};
        tbl[19] = '{8'h03, 1, 1, 1, 1, 10, 1, 0, 1, 0};
        tbl[20] = '{8'h00, 0, 0, 0, 1, 10, 1, 0, 0, 0};

        // Reset state
        RST_N = 1'b0;
        drive(8'h00, 0, 1, 0);
        repeat (2) @(posedge CLK);
        #1;
        RST_N = 1'b1;
        model_reset();
        check_outputs();
        for (int i = 0; i < 3; i++) check("IN_READY_rst", i, 32'(dut_ready[i]), 1);

        // Directed table on the STRICT instance (model still checks all three)
        for (int n = 0; n < 21; n++) begin
            drive(tbl[n].s, tbl[n].v, tbl[n].r, tbl[n].c);
            #1;
            check("tbl_IN_READY", n, 32'(dut_ready[0]), 32'(tbl[n].ready));
            cycle();
            check("tbl_O", n, 32'(dut_o[0]), tbl[n].o);
            check("tbl_O_IDX", n, 32'(dut_idx[0]), tbl[n].idx);
            check("tbl_O_VALID", n, 32'(dut_valid[0]), 32'(tbl[n].ov));
            check("tbl_SEL_ERR", n, 32'(dut_err[0]), 32'(tbl[n].err));
            check("tbl_ERR_CNT", n, 32'(cnt0), tbl[n].cnt);
        end

        // PRIORITY: highest bit wins, zero select is still an error
        drive(8'h81, 1, 1, 0);
        cycle();
        check("prio_O", 1, 32'(dut_o[1]), 40);
        check("prio_O_IDX", 1, 32'(dut_idx[1]), 7);
        check("prio_O_VALID", 1, 32'(dut_valid[1]), 1);
        check("prio_SEL_ERR", 1, 32'(dut_err[1]), 0);
        drive(8'h00, 1, 1, 0);
        cycle();
        check("prio_zero_SEL_ERR", 1, 32'(dut_err[1]), 1);
        check("prio_zero_O_VALID", 1, 32'(dut_valid[1]), 0);

        // Saturation of a 2-bit counter, then clear racing an increment
        drive(8'h00, 0, 1, 1);
        cycle();
        for (int n = 0; n < 5; n++) begin
            drive(8'h00, 1, 1, 0);
            cycle();
        end
        check("sat_ERR_CNT", 2, 32'(cnt2), 3);
        check("five_ERR_CNT", 0, 32'(cnt0), 5);
        drive(8'h00, 1, 1, 1);
        cycle();
        check("clr_ERR_CNT", 2, 32'(cnt2), 0);
        check("clr_SEL_ERR", 2, 32'(dut_err[2]), 1);

        // Reset while a result is stalled
        drive(8'h01, 1, 1, 0);
        cycle();
        drive(8'h00, 0, 0, 0);
        cycle();
        check("stall_O_VALID", 0, 32'(dut_valid[0]), 1);
        check("stall_O", 0, 32'(dut_o[0]), 5);
        RST_N = 1'b0;
        cycle();
        RST_N = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            check("rst_O", i, 32'(dut_o[i]), 0);
            check("rst_O_VALID", i, 32'(dut_valid[i]), 0);
            check("rst_ERR_CNT", i, dut_cnt(i), 0);
            check("rst_IN_READY", i, 32'(dut_ready[i]), 1);
        end

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            int pick;
            for (int k = 0; k < 8; k++) chan[k] = 16'($urandom);
            pick = $urandom_range(0, 4);
            if (pick <= 2)      s = 8'(1 << $urandom_range(0, 7));
            else if (pick == 3) s = 8'($urandom);
            else                s = 8'h00;
            in_valid = ($urandom_range(0, 3) != 0);
            o_ready  = ($urandom_range(0, 2) != 0);
            clr_err  = ($urandom_range(0, 15) == 0);
            RST_N    = ($urandom_range(0, 49) != 0);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
